fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the PC datapath. Drives a req/ack instruction memory,

---
 rtl/fetch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: req/ack imem handshake, one-entry decode slot, redirect kill.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
  parameter int WIDTH     = 32,
  parameter int INSTR_W   = 32
`ifdef FETCH_PERF_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc,
  input  logic               redirect,
  output logic               pc_en,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [WIDTH-1:0]   if_pc,
  input  logic               id_ready,
  output logic               busy
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_fetch_cnt,
  output logic [CNT_WIDTH-1:0] perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    KILL
  } state_e;

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]   ipc_q, ipc_d;

  logic slot_free;
  logic deliver;
  logic drop;
  logic live;

  assign slot_free = !vld_q || id_ready;
  assign live      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    imem_req  = 1'b0;
    imem_addr = addr_q;
    pc_en     = 1'b0;
    busy      = 1'b0;
    deliver   = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req  = slot_free;
        imem_addr = pc;
        if (redirect) begin
          pc_en = 1'b1;
          if (slot_free && imem_ack) begin
            drop = 1'b1;
          end else if (slot_free) begin
            addr_d  = pc;
            state_d = KILL;
          end
        end else if (slot_free) begin
          if (imem_ack) begin
            deliver = 1'b1;
            pc_en   = 1'b1;
          end else begin
            addr_d  = pc;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (redirect) begin
          pc_en = 1'b1;
          if (imem_ack) begin
            drop    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = KILL;
          end
        end else if (imem_ack) begin
          deliver = 1'b1;
          pc_en   = 1'b1;
          state_d = FETCH;
        end
      end
      KILL: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        // a fresh redirect still moves the PC; the old request is dropped anyway
        if (redirect) begin
          pc_en = 1'b1;
        end
        if (imem_ack) begin
          drop    = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (deliver) begin
      instr_d = imem_rdata;
      ipc_d   = imem_addr;
    end
    if (redirect && live) begin
      vld_d = 1'b0;
    end else if (deliver) begin
      vld_d = 1'b1;
    end else if (vld_q && id_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign if_valid = vld_q;
  assign if_instr = instr_q;
  assign if_pc    = ipc_q;

`ifdef FETCH_PERF_EN
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] kcnt_q, kcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    kcnt_d = kcnt_q;
    if (deliver && !(&fcnt_q)) begin
      fcnt_d = fcnt_q + 1'b1;
    end
    if (drop && !(&kcnt_q)) begin
      kcnt_d = kcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      kcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      kcnt_q <= kcnt_d;
    end
  end

  assign perf_fetch_cnt = fcnt_q;
  assign perf_kill_cnt  = kcnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: queue scoreboard on decode handoff plus
// per-cycle checks of the imem/pc_en handshake.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .redirect   (redirect),
    .pc_en      (pc_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .busy       (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  logic [63:0] sb_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] a);
    sb_q.push_back({ins, a});
  endtask

  // drive one cycle's inputs, then check the combinational handshake
  task automatic step(input logic rs, input logic [31:0] p,
                      input logic rd, input logic ak,
                      input logic [31:0] rdat, input logic rdy,
                      input logic erq, input logic [31:0] ead,
                      input logic epc, input logic ebz);
    @(posedge clk);
    #1;
    rst        = rs;
    pc         = p;
    redirect   = rd;
    imem_ack   = ak;
    imem_rdata = rdat;
    id_ready   = rdy;
    #3;
    chk("imem_req", 64'(imem_req), 64'(erq));
    if (erq) chk("imem_addr", 64'(imem_addr), 64'(ead));
    chk("pc_en", 64'(pc_en), 64'(epc));
    chk("busy", 64'(busy), 64'(ebz));
  endtask

  // monitor: every decode handoff must match the oldest expected delivery
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid && id_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", {if_instr, if_pc}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          chk("if_instr", 64'(if_instr), 64'(e[63:32]));
          chk("if_pc", 64'(if_pc), 64'(e[31:0]));
        end
      end
    end
  end

  localparam logic [31:0] I0 = 32'h0010_0093;
  localparam logic [31:0] I1 = 32'h0020_0113;
  localparam logic [31:0] I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213;
  localparam logic [31:0] I4 = 32'h0050_0293;
  localparam logic [31:0] I5 = 32'h0060_0313;
  localparam logic [31:0] I6 = 32'h0070_0393;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst        = 1'b1;
    pc         = '0;
    redirect   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    id_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_pcen", 64'(pc_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'h13);
    chk("rst_pc", 64'(if_pc), 64'd0);

    // IDLE cycle after reset release
    step(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0);
    // 0-wait back-to-back fetches
    step(0, 32'h0, 0, 1, I0, 1, 1, 32'h0, 1, 0); push(I0, 32'h0);
    step(0, 32'h4, 0, 1, I1, 1, 1, 32'h4, 1, 0); push(I1, 32'h4);
    step(0, 32'h8, 0, 1, I2, 1, 1, 32'h8, 1, 0); push(I2, 32'h8);
    // decode stall holds the slot
    step(0, 32'hC, 0, 1, BAD, 0, 0, 0, 0, 0);
    chk("stall_instr", 64'(if_instr), 64'(I2));
    chk("stall_pc", 64'(if_pc), 64'h8);
    step(0, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_valid", 64'(if_valid), 64'd1);
    // 2-cycle ack latency at 0x10
    step(0, 32'h10, 0, 0, 0, 1, 1, 32'h10, 0, 0);
    step(0, 32'h10, 0, 0, 0, 1, 1, 32'h10, 0, 1);
    step(0, 32'h10, 0, 1, I3, 1, 1, 32'h10, 1, 1); push(I3, 32'h10);
    // redirect while waiting on 0x20
    step(0, 32'h20, 0, 0, 0, 1, 1, 32'h20, 0, 0);
    step(0, 32'h20, 1, 0, 0, 1, 1, 32'h20, 1, 1);
    step(0, 32'h100, 0, 0, 0, 1, 1, 32'h20, 0, 1);
    step(0, 32'h100, 0, 1, BAD, 1, 1, 32'h20, 0, 1);
    step(0, 32'h100, 0, 0, 0, 1, 1, 32'h100, 0, 0);
    chk("kill_valid", 64'(if_valid), 64'd0);
    step(0, 32'h100, 0, 1, I4, 1, 1, 32'h100, 1, 1); push(I4, 32'h100);
    // redirect coincident with a 0-wait ack
    step(0, 32'h104, 1, 1, BAD, 1, 1, 32'h104, 1, 0);
    step(0, 32'h200, 0, 0, 0, 0, 1, 32'h200, 0, 0);
    chk("redir_valid", 64'(if_valid), 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", 64'(perf_fetch_cnt), 64'd5);
    chk("perf_kill", 64'(perf_kill_cnt), 64'd2);
`endif
    // async reset while in WAIT
    step(1, 32'h200, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("rstw_valid", 64'(if_valid), 64'd0);
    chk("rstw_instr", 64'(if_instr), 64'h13);
    chk("rstw_pc", 64'(if_pc), 64'd0);
    // late ack lands in IDLE and must be ignored
    step(0, 32'h300, 0, 1, BAD, 1, 0, 0, 0, 0);
    step(0, 32'h300, 0, 1, I5, 1, 1, 32'h300, 1, 0); push(I5, 32'h300);
    chk("late_valid", 64'(if_valid), 64'd0);
    step(0, 32'h304, 0, 1, I6, 1, 1, 32'h304, 1, 0); push(I6, 32'h304);
    step(0, 32'h308, 0, 0, 0, 1, 1, 32'h308, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch2", 64'(perf_fetch_cnt), 64'd2);
    chk("perf_kill2", 64'(perf_kill_cnt), 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
